// File: rtl/io_arbiter_if.sv
// Bus bundle for the two-requester IO arbiter: request/response handshakes,
// the shared single-port memory, and status outputs.
interface io_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64
);
   logic [0:1]                 req_valid;
   logic [0:1]                 req_ready;
   logic [0:1][0:ADDR_W-1]     req_addr;
   logic [0:1]                 req_we;
   logic [0:1][0:DATA_W-1]     req_wdata;
   logic [0:1]                 rsp_valid;
   logic [0:1]                 rsp_ready;
   logic [0:DATA_W-1]          rsp_rdata;
   logic [0:ADDR_W-1]          mem_addr;
   logic                       mem_we;
   logic [0:DATA_W-1]          mem_wdata;
   logic [0:DATA_W-1]          mem_rdata;
   logic                       busy;
   logic                       grant_id;

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wdata,
             busy, grant_id
   );

   // Requester / memory / environment side
   modport master (
      output req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wdata,
             busy, grant_id
   );
endinterface

// File: rtl/io_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with
// one-cycle read latency. One transaction in flight at a time:
// IDLE (accept) -> ISSUE (memory access) -> WAIT (capture) -> RESP (handshake).
module io_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   io_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state;
   logic                prio;
   logic                owner;
   logic                gid;
   logic                lat_we;
   logic [0:ADDR_W-1]   lat_addr;
   logic [0:DATA_W-1]   lat_wdata;
   logic [0:DATA_W-1]   rsp_q;
   logic                busy_q;
   logic                mem_we_q;
   logic                rsp_vld_q;

   logic                any_vld;
   logic                winner;
   logic                accept;

   // Winner selection: prio holder first, otherwise the other requester.
   always_comb begin
      any_vld = bus.req_valid[0] | bus.req_valid[1];
      winner  = bus.req_valid[prio] ? prio : ~prio;
      accept  = rst && (state == IDLE) && any_vld;
   end

   // Control FSM with registered busy / mem_we / rsp_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         prio      <= 1'b0;
         owner     <= 1'b0;
         gid       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_q     <= '0;
         busy_q    <= 1'b0;
         mem_we_q  <= 1'b0;
         rsp_vld_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= ISSUE;
                  owner     <= winner;
                  gid       <= winner;
                  lat_addr  <= bus.req_addr[winner];
                  lat_we    <= bus.req_we[winner];
                  lat_wdata <= bus.req_wdata[winner];
                  busy_q    <= 1'b1;
                  mem_we_q  <= bus.req_we[winner];
               end
            end
            ISSUE: begin
               state    <= WAIT;
               mem_we_q <= 1'b0;
            end
            WAIT: begin
               // Read data arrives one cycle after the address; writes answer 0.
               state     <= RESP;
               rsp_q     <= lat_we ? '0 : bus.mem_rdata;
               rsp_vld_q <= 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready[owner]) begin
                  state     <= IDLE;
                  prio      <= ~owner;
                  busy_q    <= 1'b0;
                  rsp_vld_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Per-requester handshake outputs; reset forces them low immediately.
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      for (int i = 0; i < 2; i++) begin
         bus.req_ready[i] = accept && (winner == 1'(i));
         bus.rsp_valid[i] = rst && rsp_vld_q && (owner == 1'(i));
      end
   end

   assign bus.mem_we    = rst && mem_we_q;
   assign bus.mem_addr  = busy_q ? lat_addr  : '0;
   assign bus.mem_wdata = busy_q ? lat_wdata : '0;
   assign bus.rsp_rdata = rsp_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = gid;
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the memory word address width.
REQ-002 Parameter DATA_W, default 64, SHALL set the data word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  [0:1]  SHALL carry the request-valid signal, one bit per requester.
REQ-006 req_ready  output  [0:1]  SHALL be the per-requester request accept.
REQ-007 req_addr  input  [0:1][0:ADDR_W-1]  SHALL be the per-requester word address.
REQ-008 req_we  input  [0:1]  SHALL be the per-requester write enable (1 = write, 0 = read).
REQ-009 req_wdata  input  [0:1][0:DATA_W-1]  SHALL be the per-requester write data.
REQ-010 rsp_valid  output  [0:1]  SHALL be the per-requester response valid.
REQ-011 rsp_ready  input  [0:1]  SHALL be the per-requester response accept.
REQ-012 rsp_rdata  output  [0:DATA_W-1]  SHALL be the shared response data.
REQ-013 mem_addr, mem_we, mem_wdata  output  ADDR_W / 1 / DATA_W  SHALL drive the shared memory port.
REQ-014 mem_rdata  input  [0:DATA_W-1]  SHALL be the memory read data, valid the cycle after the address is presented.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 grant_id  output  1  SHALL give the index of the current or last granted requester.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
- IDLE -> ISSUE on accept.
- ISSUE -> WAIT unconditionally.
- WAIT -> RESP unconditionally.
- RESP -> IDLE when rsp_valid and rsp_ready of the owner are both high.
REQ-018 In IDLE, the arbiter SHALL select a winner as follows: prio if req_valid[prio] is high, otherwise the other requester if its req_valid is high.
REQ-019 req_ready[winner] SHALL be asserted combinationally in IDLE only, and only to the winner. Accept occurs that cycle.
REQ-020 On accept, the arbiter SHALL latch addr, we, wdata and owner id, and update grant_id to the owner id.
- Later changes on the req_* inputs SHALL be ignored until the next accept.
REQ-021 Withdrawing req_valid before accept SHALL be legal and SHALL commit nothing.
REQ-022 In ISSUE, WAIT and RESP, mem_addr SHALL equal the latched address and mem_wdata the latched data.
- In IDLE, mem_addr and mem_wdata SHALL be 0.
REQ-023 mem_we SHALL be 1 only in ISSUE with a latched write, and SHALL be 0 in every other state.
- Each accepted write SHALL produce exactly one mem_we cycle.
REQ-024 In WAIT, the arbiter SHALL capture mem_rdata into the response register for a read, or 0 for a write.
REQ-025 In RESP, rsp_valid[owner] SHALL be high and held until rsp_ready[owner] is high.
- rsp_rdata SHALL stay stable while rsp_valid is high.
- rsp_valid of the non-owner SHALL always be 0.
REQ-026 Timing: accept at cycle T, memory access at T+1, capture at T+2, rsp_valid first high at T+3.
- Back-to-back accept is possible no earlier than the cycle after the response handshake.
REQ-027 On the response handshake, prio SHALL become the inverse of the owner id, giving round-robin arbitration.
- With both requesters continuously valid, grants SHALL alternate 0,1,0,1...
REQ-028 Writes SHALL also return a response, with rsp_rdata = 0.
REQ-029 At most one transaction SHALL be outstanding. No request SHALL be accepted while busy is high.

Reset
REQ-030 When rst = 0 at a rising edge, the block SHALL reset to:
- state IDLE;
- prio = 0 and grant_id = 0;
- latched registers and response register = 0.
REQ-031 While rst = 0, the outputs SHALL be forced as follows: mem_we = 0, req_ready = 0, rsp_valid = 0.
REQ-032 Reset in any state SHALL abort the in-flight transaction. No response and no mem_we SHALL follow the reset edge.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Single read: req0 reads addr 0x005 with memory[5] = 0xDEADBEEF00000001, rsp_ready tied high -> req_ready[0] at T, mem_addr = 0x005 at T+1, rsp_valid[0] at T+3 with rsp_rdata = 0xDEADBEEF00000001.
- Write then read: req1 writes 0x1234 to addr 0x0FF, then reads addr 0x0FF -> exactly one mem_we pulse; the write rsp_rdata = 0; the read returns 0x1234.
- Contention: both requesters continuously valid for 4 transactions after reset -> grants 0,1,0,1.
- Backpressure: rsp_ready[0] held low for 5 cycles in RESP -> rsp_valid[0] and rsp_rdata stable, busy = 1, req_ready = 0 throughout; release -> IDLE next cycle.
- Reset mid-op: rst = 0 asserted during ISSUE of a write -> mem_we = 0 that cycle; after release, no rsp_valid and busy = 0.
